apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

Parameterised APB (v3-style) memory slave with configurable data width, depth and wait states, byte write strobes, and error signalling. It sits on the peripheral bus behind the APB bridge/decoder as the team's generic register/scratch-memory target. It adds three capabilities a basic APB slave lacks: a clean two-phase FSM, PREADY-based wait insertion, and a PSLVERR response for illegal accesses.

## Interface

- DATA_WIDTH, 32: data bus width in bits; must be 8, 16, 32 or 64.
- ADDR_WIDTH, 32: Paddr width in bits.
- DEPTH, 32: number of DATA_WIDTH-bit words.
- WAIT_STATES, 0: number of ACCESS cycles with Pready low before completion; range 0–15.
- Pclk  in  1  clock; all logic on the rising edge.
- Prst  in  1  reset; synchronous and active-high.
- Pselx  in  1  slave select.
- Penable  in  1  access-phase indicator.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  ADDR_WIDTH  byte address.
- Pwdata  in  DATA_WIDTH  write data.
- Pstrb  in  DATA_WIDTH/8  byte write strobes; ignored on reads.
- Pready  out  1  transfer completion.
- Pslverr  out  1  error response; valid only while Pready=1.
- Prdata  out  DATA_WIDTH  read data; valid while Pready=1 on a read.

## Operation

- Address decoding:
  - BW = DATA_WIDTH/8 and LSB = log2(BW).
  - Word index idx = Paddr >> LSB.
- A transfer is illegal, and terminates with Pslverr=1, if either condition holds:
  - misaligned: Paddr[LSB-1:0] != 0 (not checked when DATA_WIDTH=8);
  - out of range: idx >= DEPTH.
- Illegal writes leave memory unchanged. Illegal reads return Prdata = 0.
- FSM states:
  - IDLE: if Pselx=1 and Penable=0 at an edge, latch addr/dir/strb/wdata and the error flag, load wcnt = WAIT_STATES, and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS, wcnt != 0: Pready=0 and wcnt decrements each edge.
  - ACCESS, wcnt == 0: Pready=1. At the next edge the transfer commits and the FSM returns to IDLE.
  - ACCESS, Pselx=0 or Penable=0 sampled at an edge before completion: abort, no write, return to IDLE. This is a protocol violation and produces no error response.
- Write commit: for each byte b with Pstrb[b]=1, mem[idx] byte b = latched Pwdata byte b. Pstrb = 0 produces a legal no-op write.
- Read data: Prdata is registered and loaded from mem[idx] (or 0 if illegal) on the setup-accept edge. It holds until the next read is accepted.
- Outputs:
  - Pready = (state == ACCESS) && (wcnt == 0).
  - Pslverr = Pready && latched error flag.
- Pwdata/Pstrb/Paddr changes during ACCESS are ignored; the latched values are used.

## Timing

- Reset: state=IDLE, wcnt=0, Pready=0, Pslverr=0, Prdata=0, all memory words = 0.
- Reset applies on the first edge with Prst=1. A transfer in progress is dropped with no write, and Pready is 0 in the following cycle.
- Transfer latency is 2 + WAIT_STATES cycles from the setup cycle to the completion edge inclusive:
  - setup cycle: Pready=0;
  - W wait cycles: Pready=0;
  - one completion cycle: Pready=1.
- Back-to-back transfers:
  - A new setup phase may be driven in the cycle immediately after completion, giving no idle gap.
  - In IDLE, a cycle with Pselx=1 and Penable=1 (no setup) is ignored.
- A read following a write to the same address returns the new data, because the write commits before the next setup is sampled.
- Pready is combinational from registered state only; it has no combinational path from the inputs.

## Test plan

- Reset, then read idx 5 with WAIT_STATES=0 -> Pready high in the 2nd cycle, Prdata=0, Pslverr=0.
- Write 0xDEADBEEF to Paddr 0x10 with Pstrb=4'b1111, then write 0x000000AA with Pstrb=4'b0001, then read 0x10 -> Prdata=0xDEADBEAA. Transfers run back-to-back with no idle cycles.
- With WAIT_STATES=3, write then read 0x04 -> Pready low for 3 ACCESS cycles, high on the 4th. Total 5 cycles per transfer; data matches.
- Read Paddr 0x80 (idx 32, DEPTH=32) and write Paddr 0x02 (misaligned) -> both complete with Pslverr=1. Read returns Prdata=0; memory is unchanged (reads of 0x00 afterwards return the prior value).
- Issue a write with WAIT_STATES=2 and drop Pselx during the 2nd ACCESS cycle -> FSM returns to IDLE, no Pready pulse, and target word unchanged.
- Assert Prst in the middle of a wait state -> the next cycle has Pready=0 and Prdata=0, and all words read back 0.

Source files
------------

// File: rtl/apb_mem_slave_if.sv
// apb_mem_slave_if
//   APB (v3-style) bus bundle between a master/decoder and apb_mem_slave.
//   Ports (signals):
//     Pselx, Penable, Pwrite : master -> slave control
//     Paddr [ADDR_WIDTH]      : byte address
//     Pwdata [DATA_WIDTH]     : write data
//     Pstrb [DATA_WIDTH/8]    : byte write strobes
//     Pready, Pslverr         : slave -> master completion / error
//     Prdata [DATA_WIDTH]     : read data
interface apb_mem_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                      Pselx;
  logic                      Penable;
  logic                      Pwrite;
  logic [ADDR_WIDTH-1:0]     Paddr;
  logic [DATA_WIDTH-1:0]     Pwdata;
  logic [DATA_WIDTH/8-1:0]   Pstrb;
  logic                      Pready;
  logic                      Pslverr;
  logic [DATA_WIDTH-1:0]     Prdata;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
    input  Pready, Pslverr, Prdata
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
    output Pready, Pslverr, Prdata
  );
endinterface

// File: rtl/apb_mem_slave.sv
// apb_mem_slave
//   Generic APB memory target: DEPTH words of DATA_WIDTH bits, byte strobes,
//   WAIT_STATES cycles of Pready-low wait insertion and Pslverr for
//   misaligned or out-of-range accesses.
//   Ports:
//     Pclk : clock, rising edge
//     Prst : synchronous active-high reset (clears FSM, read data and memory)
//     bus  : apb_mem_slave_if slave modport (Pselx/Penable/Pwrite/Paddr/
//            Pwdata/Pstrb in, Pready/Pslverr/Prdata out)
module apb_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                 Pclk,
  input  logic                 Prst,
  apb_mem_slave_if.slave       bus
);

  localparam int BW   = DATA_WIDTH / 8;
  localparam int LSB  = (BW > 1) ? $clog2(BW) : 0;
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic                    wr_q, wr_d;
  logic                    err_q, err_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [BW-1:0]           strb_q, strb_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    mem_we;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Decode of the address currently on the bus (used only at setup accept).
  logic [ADDR_WIDTH-1:0]   idx_full;
  logic [IDXW-1:0]         acc_idx;
  logic                    acc_misal;
  logic                    acc_err;

  always_comb begin
    idx_full  = bus.Paddr >> LSB;
    acc_idx   = idx_full[IDXW-1:0];
    // Masking with BW-1 makes the alignment check vanish for byte-wide buses.
    acc_misal = (bus.Paddr & ADDR_WIDTH'(BW - 1)) != '0;
    acc_err   = acc_misal || (idx_full >= ADDR_WIDTH'(DEPTH));
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    wr_d     = wr_q;
    err_d    = err_q;
    idx_d    = idx_q;
    strb_d   = strb_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        // Only a true setup phase starts a transfer; Pselx&Penable in IDLE is ignored.
        if (bus.Pselx && !bus.Penable) begin
          state_d = ACCESS;
          wcnt_d  = 4'(WAIT_STATES);
          wr_d    = bus.Pwrite;
          err_d   = acc_err;
          idx_d   = acc_idx;
          strb_d  = bus.Pstrb;
          wdata_d = bus.Pwdata;
          if (!bus.Pwrite) begin
            prdata_d = acc_err ? '0 : mem_q[acc_idx];
          end
        end
      end
      ACCESS: begin
        if (!(bus.Pselx && bus.Penable)) begin
          // Master abandoned the transfer: drop it silently.
          state_d = IDLE;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          mem_we  = wr_q && !err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered stage: control, read data and memory (all cleared by reset)
  always_ff @(posedge Pclk) begin
    if (Prst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
      if (mem_we) begin
        for (int b = 0; b < BW; b++) begin
          if (strb_q[b]) begin
            mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

  // Latched transfer payload; meaningful only while in ACCESS
  always_ff @(posedge Pclk) begin
    idx_q   <= idx_d;
    strb_q  <= strb_d;
    wdata_q <= wdata_d;
  end

  assign bus.Pready  = (state_q == ACCESS) && (wcnt_q == 4'd0);
  assign bus.Pslverr = bus.Pready && err_q;
  assign bus.Prdata  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

  logic        clk;
  logic        prst;
  logic        psel;
  logic        pen;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          tgt;

  logic        rdy;
  logic        err;
  logic [31:0] rdata;

  int n_cmp;
  int n_fail;

  apb_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
  apb_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();
  apb_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus3 ();

  assign bus0.Pselx = psel && (tgt == 0);
  assign bus2.Pselx = psel && (tgt == 2);
  assign bus3.Pselx = psel && (tgt == 3);
  assign bus0.Penable = pen && (tgt == 0);
  assign bus2.Penable = pen && (tgt == 2);
  assign bus3.Penable = pen && (tgt == 3);
  assign bus0.Pwrite = pwrite;
  assign bus2.Pwrite = pwrite;
  assign bus3.Pwrite = pwrite;
  assign bus0.Paddr = paddr;
  assign bus2.Paddr = paddr;
  assign bus3.Paddr = paddr;
  assign bus0.Pwdata = pwdata;
  assign bus2.Pwdata = pwdata;
  assign bus3.Pwdata = pwdata;
  assign bus0.Pstrb = pstrb;
  assign bus2.Pstrb = pstrb;
  assign bus3.Pstrb = pstrb;

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) u_ws0 (
    .Pclk(clk), .Prst(prst), .bus(bus0));
  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(2)) u_ws2 (
    .Pclk(clk), .Prst(prst), .bus(bus2));
  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(3)) u_ws3 (
    .Pclk(clk), .Prst(prst), .bus(bus3));

  always_comb begin
    rdy   = bus0.Pready;
    err   = bus0.Pslverr;
    rdata = bus0.Prdata;
    if (tgt == 2) begin
      rdy = bus2.Pready; err = bus2.Pslverr; rdata = bus2.Prdata;
    end else if (tgt == 3) begin
      rdy = bus3.Pready; err = bus3.Pslverr; rdata = bus3.Prdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one transfer starting #1 after a rising edge and returns #1 after
  // the completion edge with the bus released (next setup may follow at once).
  task automatic apb_xfer(input int t, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic er,
                          output int cyc, output logic early);
    logic done;
    tgt = t; psel = 1'b1; pen = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    rd = '0; er = 1'b0; done = 1'b0;
    @(negedge clk);
    early = rdy;
    cyc = 1;
    @(posedge clk); #1;
    pen = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (rdy) begin
        rd = rdata; er = err; done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) cyc = 99;
    psel = 1'b0; pen = 1'b0;
  endtask

  task automatic test_reset;
    prst = 1'b1; psel = 1'b0; pen = 1'b0; tgt = 0;
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus0.Pready !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_ws0: got %b expected 0", bus0.Pready); end
    n_cmp++; if (bus0.Pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_err_ws0: got %b expected 0", bus0.Pslverr); end
    n_cmp++; if (bus0.Prdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_ws0: got %h expected 0", bus0.Prdata); end
    n_cmp++; if (bus2.Pready !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_ws2: got %b expected 0", bus2.Pready); end
    n_cmp++; if (bus3.Prdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_ws3: got %h expected 0", bus3.Prdata); end
    @(posedge clk); #1;
    prst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_read;
    logic [31:0] rd; logic er; int cyc; logic early;
    apb_xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, cyc, early);
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL basic_setup_rdy: got %b expected 0", early); end
    n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected 2", cyc); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL basic_rdata: got %h expected 0", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", er); end
  endtask

  task automatic test_strobe_back_to_back;
    logic [31:0] rd; logic er; int cyc; logic early;
    apb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, cyc, early);
    n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL b2b_wr1_latency: got %0d expected 2", cyc); end
    apb_xfer(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, cyc, early);
    n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL b2b_wr2_latency: got %0d expected 2", cyc); end
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL b2b_wr2_setup_rdy: got %b expected 0", early); end
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc, early);
    n_cmp++; if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL b2b_rdata: got %h expected deadbeaa", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b expected 0", er); end
    n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL b2b_rd_latency: got %0d expected 2", cyc); end
  endtask

  task automatic test_wait_states;
    logic [31:0] rd; logic er; int cyc; logic early;
    apb_xfer(3, 1'b1, 32'h04, 32'h12345678, 4'b1111, rd, er, cyc, early);
    n_cmp++; if (cyc != 5) begin n_fail++; $display("FAIL ws3_wr_latency: got %0d expected 5", cyc); end
    apb_xfer(3, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc, early);
    n_cmp++; if (cyc != 5) begin n_fail++; $display("FAIL ws3_rd_latency: got %0d expected 5", cyc); end
    n_cmp++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL ws3_rdata: got %h expected 12345678", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int cyc; logic early;
    apb_xfer(0, 1'b1, 32'h00, 32'hCAFEF00D, 4'b1111, rd, er, cyc, early);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL err_legal_wr: got %b expected 0", er); end
    apb_xfer(0, 1'b0, 32'h80, 32'h0, 4'h0, rd, er, cyc, early);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_range_rd_err: got %b expected 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_range_rd_data: got %h expected 0", rd); end
    n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL err_range_latency: got %0d expected 2", cyc); end
    apb_xfer(0, 1'b1, 32'h02, 32'hFFFFFFFF, 4'b1111, rd, er, cyc, early);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_misal_wr_err: got %b expected 1", er); end
    apb_xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, rd, er, cyc, early);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_mem_unchanged: got %h expected cafef00d", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL err_after_clear: got %b expected 0", er); end
  endtask

  task automatic test_idle_ignore;
    tgt = 0; psel = 1'b1; pen = 1'b1; pwrite = 1'b1; paddr = 32'h00;
    pwdata = 32'h0BADBAD0; pstrb = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_rdy%0d: got %b expected 0", i, rdy); end
      @(posedge clk); #1;
    end
    psel = 1'b0; pen = 1'b0;
  endtask

  task automatic test_abort;
    logic [31:0] rd; logic er; int cyc; logic early;
    apb_xfer(2, 1'b1, 32'h08, 32'h11112222, 4'b1111, rd, er, cyc, early);
    n_cmp++; if (cyc != 4) begin n_fail++; $display("FAIL abort_ws2_latency: got %0d expected 4", cyc); end
    tgt = 2; psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 32'h08;
    pwdata = 32'h99999999; pstrb = 4'b1111;
    @(posedge clk); #1;
    pen = 1'b1;
    @(negedge clk);
    n_cmp++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL abort_access1_rdy: got %b expected 0", rdy); end
    @(posedge clk); #1;
    psel = 1'b0; pen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready%0d: got %b expected 0", i, rdy); end
      @(posedge clk); #1;
    end
    apb_xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc, early);
    n_cmp++; if (rd !== 32'h11112222) begin n_fail++; $display("FAIL abort_word_kept: got %h expected 11112222", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int cyc; logic early;
    apb_xfer(3, 1'b1, 32'h0C, 32'h55AA55AA, 4'b1111, rd, er, cyc, early);
    apb_xfer(3, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc, early);
    n_cmp++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL rstmid_pre_rdata: got %h expected 12345678", rd); end
    tgt = 3; psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
    pwdata = 32'h77777777; pstrb = 4'b1111;
    @(posedge clk); #1;
    pen = 1'b1;
    @(posedge clk); #1;
    prst = 1'b1;
    @(negedge clk);
    n_cmp++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_wait_rdy: got %b expected 0", rdy); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdy: got %b expected 0", rdy); end
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected 0", rdata); end
    @(posedge clk); #1;
    prst = 1'b0; psel = 1'b0; pen = 1'b0;
    @(posedge clk); #1;
    apb_xfer(3, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, cyc, early);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_word0c: got %h expected 0", rd); end
    apb_xfer(3, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc, early);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_word04: got %h expected 0", rd); end
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc, early);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_ws0_word10: got %h expected 0", rd); end
    apb_xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc, early);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_ws2_word08: got %h expected 0", rd); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset;
    test_basic_read;
    test_strobe_back_to_back;
    test_wait_states;
    test_errors;
    test_idle_ignore;
    test_abort;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
